// File: rtl/out_port_tx_pkg.sv
// Shared definitions for the OUT serial port: FSM state encodings and the ALU OUT opcode.
// The state width grows to 3 bits when OUT_PORT_PARITY_EN is defined.
package out_port_tx_pkg;

`ifdef OUT_PORT_PARITY_EN
    localparam int STATE_W = 3;
`else
    localparam int STATE_W = 2;
`endif

    localparam logic [STATE_W-1:0] ST_IDLE   = STATE_W'(0);
    localparam logic [STATE_W-1:0] ST_START  = STATE_W'(1);
    localparam logic [STATE_W-1:0] ST_DATA   = STATE_W'(2);
    localparam logic [STATE_W-1:0] ST_STOP   = STATE_W'(3);
`ifdef OUT_PORT_PARITY_EN
    localparam logic [STATE_W-1:0] ST_PARITY = STATE_W'(4);
`endif

    // op3 code the core decodes into the out_we strobe.
    localparam logic [3:0] ALU_OP3_OUT = 4'b1101;

    localparam int WORD_W = 16;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/out_port_fifo.sv
// Synchronous FIFO with registered full flag and an explicit occupancy count.
// A push while full is ignored even if a pop happens on the same edge.
module out_port_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [AW:0]      count_next;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == FULL_CNT);
        end
    end

    // NOTE: the storage array has no reset; an entry is never read before it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/out_port_tx.sv
// OUT port: buffers 16-bit words and sends each as two 8N1 frames, high byte first.
// Define OUT_PORT_PARITY_EN to insert an even-parity bit before each stop bit.
module out_port_tx
    import out_port_tx_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              out_we,
    input  logic [WORD_W-1:0] out_data,
    output logic              out_full,
    output logic              out_ovf,
    output logic              tx,
    output logic              tx_busy
);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic [STATE_W-1:0] state;
    logic [CW-1:0]      baud_cnt;
    logic [2:0]         bit_idx;
    logic [2:0]         bit_idx_next;
    logic               byte_idx;
    logic [WORD_W-1:0]  sh;
    logic               tx_q;
    logic               ovf_q;
    logic [7:0]         cur_byte;
    logic               baud_done;

    logic               fifo_pop;
    logic               fifo_empty;
    logic [WORD_W-1:0]  fifo_rdata;
    logic [CNT_W-1:0]   fifo_count;

    assign fifo_pop     = (state == ST_IDLE) && !fifo_empty;
    assign cur_byte     = byte_idx ? sh[7:0] : sh[15:8];
    assign baud_done    = (baud_cnt == BAUD_LAST);
    assign bit_idx_next = bit_idx + 3'd1;

    out_port_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (out_we),
        .pop   (fifo_pop),
        .wdata (out_data),
        .rdata (fifo_rdata),
        .full  (out_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // tx_q is loaded with the level of the state being entered, so the line is a clean flop output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= 1'b0;
            sh       <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (out_we && out_full) begin
                ovf_q <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (!fifo_empty) begin
                        sh       <= fifo_rdata;
                        byte_idx <= 1'b0;
                        state    <= ST_START;
                        tx_q     <= 1'b0;
                    end
                end

                ST_START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                        tx_q     <= cur_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef OUT_PORT_PARITY_EN
                            state <= ST_PARITY;
                            tx_q  <= even_parity(cur_byte);
`else
                            state <= ST_STOP;
                            tx_q  <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx_next;
                            tx_q    <= cur_byte[bit_idx_next];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

`ifdef OUT_PORT_PARITY_EN
                ST_PARITY: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= ST_STOP;
                        tx_q     <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (!byte_idx) begin
                            byte_idx <= 1'b1;
                            state    <= ST_START;
                            tx_q     <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    baud_cnt <= '0;
                    tx_q     <= 1'b1;
                end
            endcase
        end
    end

    assign tx      = tx_q;
    assign out_ovf = ovf_q;
    assign tx_busy = (state != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_out_port_tx.sv
// Self-checking bench for out_port_tx: a queue-based line model compared every cycle,
// plus literal checks of frame timing, byte order, overflow and mid-frame reset.
module tb_out_port_tx;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
`ifdef OUT_PORT_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME  = NBITS * CPB;
    localparam int TR_LEN = 2 * FRAME + 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_we = 1'b0;
    logic [15:0] out_data = '0;
    logic        out_full;
    logic        out_ovf;
    logic        tx;
    logic        tx_busy;

    always #5 clk = ~clk;

    out_port_tx #(
        .DEPTH(DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .out_we   (out_we),
        .out_data (out_data),
        .out_full (out_full),
        .out_ovf  (out_ovf),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a word queue and the list of line levels still to be driven.
    logic [15:0] m_q[$];
    logic        m_line[$];
    logic        m_ovf = 1'b0;
    logic        m_idle;
    logic        m_full_pre;
    logic        m_pop;
    logic [15:0] m_word;

    task automatic push_level(input logic v);
        repeat (CPB) m_line.push_back(v);
    endtask

    task automatic load_frames(input logic [15:0] w);
        logic [7:0] b;
        for (int k = 0; k < 2; k++) begin
            b = (k == 0) ? w[15:8] : w[7:0];
            push_level(1'b0);
            for (int i = 0; i < 8; i++) push_level(b[i]);
`ifdef OUT_PORT_PARITY_EN
            push_level(^b);
`endif
            push_level(1'b1);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_line.delete();
            m_ovf = 1'b0;
        end else begin
            m_idle     = (m_line.size() == 0);
            m_full_pre = (m_q.size() == DEPTH);
            m_pop      = m_idle && (m_q.size() != 0);
            if (m_pop) m_word = m_q.pop_front();
            if (out_we) begin
                if (m_full_pre) m_ovf = 1'b1;
                else m_q.push_back(out_data);
            end
            if (!m_idle) m_line.delete(0);
            if (m_pop) load_frames(m_word);
        end
    end

    logic cmp_en = 1'b0;
    logic exp_tx;

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_tx = (m_line.size() != 0) ? m_line[0] : 1'b1;
            check("model_tx", tx, exp_tx);
            check("model_busy", tx_busy, (m_line.size() != 0) || (m_q.size() != 0));
            check("model_full", out_full, m_q.size() == DEPTH);
            check("model_ovf", out_ovf, m_ovf);
        end
    end

    logic tr[TR_LEN];
    logic bz[TR_LEN];

    // Writes w while idle; tr[n]/bz[n] hold tx/tx_busy n cycles after the write edge.
    task automatic trace_word(input logic [15:0] w);
        out_we   = 1'b1;
        out_data = w;
        for (int n = 1; n < TR_LEN; n++) begin
            @(negedge clk);
            out_we = 1'b0;
            tr[n]  = tx;
            bz[n]  = tx_busy;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx_busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", tx_busy, 1'b0);
        @(negedge clk);
    endtask

    // Receives one frame by finding its start bit and sampling mid-bit.
    task automatic get_byte(output logic [7:0] b);
        int n = 0;
        b = '0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 400);
        if (tx !== 1'b0) begin
            check("rx_start_timeout", tx, 1'b0);
            return;
        end
        repeat (CPB + 1) @(negedge clk);
        b[0] = tx;
        for (int i = 1; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
`ifdef OUT_PORT_PARITY_EN
        repeat (CPB) @(negedge clk);
        check("rx_parity", tx, ^b);
`endif
        repeat (CPB) @(negedge clk);
        check("rx_stop", tx, 1'b1);
    endtask

    logic [7:0] rx[10];
    logic [7:0] b_hi;
    logic [7:0] b_lo;

    initial begin
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        rst    = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_tx", tx, 1'b1);
            check("idle_busy", tx_busy, 1'b0);
            check("idle_full", out_full, 1'b0);
            check("idle_ovf", out_ovf, 1'b0);
        end

        trace_word(16'h41A5);
        check("sw_pre_start", tr[1], 1'b1);
        check("sw_start", tr[2], 1'b0);
        check("sw_start_last", tr[1 + CPB], 1'b0);
        for (int i = 0; i < 8; i++) begin
            b_hi[i] = tr[2 + CPB + 1 + CPB * i];
            b_lo[i] = tr[2 + FRAME + CPB + 1 + CPB * i];
        end
        check("sw_byte_hi", b_hi, 8'h41);
        check("sw_byte_lo", b_lo, 8'hA5);
        check("sw_stop1_last", tr[1 + FRAME], 1'b1);
        check("sw_frame2_start", tr[2 + FRAME], 1'b0);
        check("sw_busy_last", bz[1 + 2 * FRAME], 1'b1);
        check("sw_busy_fall", bz[2 + 2 * FRAME], 1'b0);

`ifdef OUT_PORT_PARITY_EN
        wait_idle();
        trace_word(16'h0703);
        check("par_bit_07", tr[2 + 9 * CPB + 1], 1'b1);
        check("par_bit_03", tr[2 + FRAME + 9 * CPB + 1], 1'b0);
        check("par_frame2_start", tr[2 + 44], 1'b0);
`endif

        wait_idle();
        fork
            begin
                for (int k = 1; k <= 5; k++) begin
                    out_we   = 1'b1;
                    out_data = 16'(k);
                    @(negedge clk);
                    check("five_full", out_full, k == 5);
                end
                out_we = 1'b0;
            end
            begin
                for (int j = 0; j < 10; j++) get_byte(rx[j]);
            end
        join
        for (int j = 0; j < 10; j++) begin
            check("five_line", rx[j], (j % 2 == 0) ? 8'h00 : 8'((j / 2) + 1));
        end
        check("five_no_ovf", out_ovf, 1'b0);

        wait_idle();
        for (int c = 0; c < 1500; c++) begin
            out_we   = !out_full && ($urandom_range(0, 2) == 0);
            out_data = 16'($urandom);
            @(negedge clk);
        end
        out_we = 1'b0;
        wait_idle();
        check("rand_no_ovf", out_ovf, 1'b0);

        for (int k = 0; k < 6; k++) begin
            out_we   = 1'b1;
            out_data = 16'hA0 + 16'(k);
            @(negedge clk);
            check("ovf_step", out_ovf, k == 5);
        end
        out_we = 1'b0;
        check("ovf_full", out_full, 1'b1);
        wait_idle();
        check("ovf_sticky", out_ovf, 1'b1);

        out_we   = 1'b1;
        out_data = 16'h1234;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            out_we = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_full", out_full, 1'b0);
        check("rst_ovf", out_ovf, 1'b0);
        fork
            begin
                out_we   = 1'b1;
                out_data = 16'hC35A;
                @(negedge clk);
                out_we = 1'b0;
            end
            begin
                get_byte(b_hi);
                get_byte(b_lo);
            end
        join
        check("rst_next_hi", b_hi, 8'hC3);
        check("rst_next_lo", b_lo, 8'h5A);

        wait_idle();
        for (int c = 0; c < 800; c++) begin
            out_we   = ($urandom_range(0, 3) == 0);
            out_data = 16'($urandom);
            @(negedge clk);
        end
        out_we = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
